// File: rtl/integrator_pkg.sv
// Shared saturation helpers and status encoding for the forward-Euler integrator.
package integrator_pkg;

    typedef enum logic [1:0] {SAT_NONE, SAT_POS, SAT_NEG} sat_e;

    function automatic int sat_max(input int L);
        return (1 << (L - 1)) - 1;
    endfunction

    function automatic int sat_min(input int L);
        return -(1 << (L - 1));
    endfunction

endpackage

// File: rtl/integrator_fwd_if.sv
// Sample/state bundle of the integrator; the master drives samples, the slave returns state and flags.
interface integrator_fwd_if #(parameter int LENGTH = 5);
    logic signed [LENGTH-1:0] DATA_I;
    logic signed [LENGTH-1:0] DATA_O;
    logic                     OFDET_O;
    logic                     UFDET_O;

    modport master (output DATA_I, input DATA_O, OFDET_O, UFDET_O);
    modport slave  (input DATA_I, output DATA_O, OFDET_O, UFDET_O);
endinterface

// File: rtl/integrator_fwd_sat_add_s.sv
// Combinational signed saturating adder; ovf/unf mark clamping towards MAX/MIN.
module sat_add_s
    import integrator_pkg::*;
#(
    parameter int LENGTH = 5
) (
    input  logic signed [LENGTH-1:0] a,
    input  logic signed [LENGTH-1:0] b,
    output logic signed [LENGTH-1:0] result,
    output logic                     ovf,
    output logic                     unf
);
    logic [LENGTH:0] sum;
    logic            wrap;

    // One guard bit: a mismatch between the two top bits means the true sum left the range.
    assign sum  = {a[LENGTH-1], a} + {b[LENGTH-1], b};
    assign wrap = sum[LENGTH] != sum[LENGTH-1];
    assign ovf  = wrap & ~sum[LENGTH];
    assign unf  = wrap & sum[LENGTH];

    always_comb begin
        result = sum[LENGTH-1:0];
        if (ovf)
            result = LENGTH'(sat_max(LENGTH));
        else if (unf)
            result = LENGTH'(sat_min(LENGTH));
    end
endmodule

// File: rtl/integrator_fwd.sv
// Saturating forward-Euler integrator: y[n] = sat(y[n-1] + x[n-1]), one sample per clock.
module integrator_fwd
    import integrator_pkg::*;
#(
    parameter int LENGTH    = 5,
    parameter bit INPUT_REG = 1'b1
) (
    input  logic               CLK_I,
    input  logic               ARESETN_I,
    integrator_fwd_if.slave    bus
);
    logic signed [LENGTH-1:0] x_q;
    logic signed [LENGTH-1:0] acc;
    logic signed [LENGTH-1:0] sum_res;
    logic                     ovf;
    logic                     unf;
    logic                     of_q;
    logic                     uf_q;
    sat_e                     st;

    generate
        if (LENGTH < 2) begin : g_len_chk
            $error("integrator_fwd: LENGTH must be >= 2");
        end

        if (INPUT_REG) begin : g_in_reg
            logic signed [LENGTH-1:0] x_r;
            always_ff @(posedge CLK_I or negedge ARESETN_I) begin
                if (!ARESETN_I) x_r <= '0;
                else            x_r <= bus.DATA_I;
            end
            assign x_q = x_r;
        end else begin : g_in_direct
            assign x_q = bus.DATA_I;
        end
    endgenerate

    sat_add_s #(.LENGTH(LENGTH)) u_add (
        .a      (acc),
        .b      (x_q),
        .result (sum_res),
        .ovf    (ovf),
        .unf    (unf)
    );

    always_comb begin
        st = SAT_NONE;
        if (ovf)      st = SAT_POS;
        else if (unf) st = SAT_NEG;
    end

    // Flags are rewritten on every update, so they track only the latest sum.
    always_ff @(posedge CLK_I or negedge ARESETN_I) begin
        if (!ARESETN_I) begin
            acc  <= '0;
            of_q <= 1'b0;
            uf_q <= 1'b0;
        end else begin
            acc  <= sum_res;
            of_q <= (st == SAT_POS);
            uf_q <= (st == SAT_NEG);
        end
    end

    assign bus.DATA_O  = acc;
    assign bus.OFDET_O = of_q;
    assign bus.UFDET_O = uf_q;
endmodule

// File: tb/tb_integrator_fwd.sv
// Randomized self-checking bench: registered-input and direct-input integrators against a clamp model.
module tb_integrator_fwd;
    localparam int L    = 5;
    localparam int MAXV = 15;
    localparam int MINV = -16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   din = 0;

    // reference state: DUT with input register (suffix 1) and without (suffix 0)
    int m_y1 = 0, m_x1 = 0, m_y0 = 0;
    bit m_of1 = 0, m_uf1 = 0, m_of0 = 0, m_uf0 = 0;

    integrator_fwd_if #(.LENGTH(L)) bus1 ();
    integrator_fwd_if #(.LENGTH(L)) bus0 ();

    integrator_fwd #(.LENGTH(L), .INPUT_REG(1'b1)) dut1 (.CLK_I(clk), .ARESETN_I(rst_n), .bus(bus1));
    integrator_fwd #(.LENGTH(L), .INPUT_REG(1'b0)) dut0 (.CLK_I(clk), .ARESETN_I(rst_n), .bus(bus0));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tests++;
        if ((bus1.OFDET_O && bus1.UFDET_O) || (bus0.OFDET_O && bus0.UFDET_O)) begin
            fails++;
            $display("FAIL flag_excl: of1=%b uf1=%b of0=%b uf0=%b, required not both high",
                     bus1.OFDET_O, bus1.UFDET_O, bus0.OFDET_O, bus0.UFDET_O);
        end
        tests++;
        if ((bus1.OFDET_O && bus1.DATA_O !== 5'b01111) || (bus1.UFDET_O && bus1.DATA_O !== 5'b10000) ||
            (bus0.OFDET_O && bus0.DATA_O !== 5'b01111) || (bus0.UFDET_O && bus0.DATA_O !== 5'b10000)) begin
            fails++;
            $display("FAIL flag_rail: d1=%b of1=%b uf1=%b d0=%b of0=%b uf0=%b, required flag implies rail",
                     bus1.DATA_O, bus1.OFDET_O, bus1.UFDET_O, bus0.DATA_O, bus0.OFDET_O, bus0.UFDET_O);
        end
    end

    task automatic set_in(input int v);
        din = v;
        bus1.DATA_I = L'(v);
        bus0.DATA_I = L'(v);
    endtask

    // Advance one clock and update the model with plain clamped integer arithmetic.
    task automatic step();
        int s;
        @(posedge clk);
        s = m_y1 + m_x1;
        m_of1 = s > MAXV;
        m_uf1 = s < MINV;
        m_y1 = m_of1 ? MAXV : (m_uf1 ? MINV : s);
        m_x1 = din;
        s = m_y0 + din;
        m_of0 = s > MAXV;
        m_uf0 = s < MINV;
        m_y0 = m_of0 ? MAXV : (m_uf0 ? MINV : s);
        #1;
    endtask

    task automatic pulse_reset(input string name);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (bus1.DATA_O !== 5'd0 || bus1.OFDET_O !== 1'b0 || bus1.UFDET_O !== 1'b0 ||
            bus0.DATA_O !== 5'd0 || bus0.OFDET_O !== 1'b0 || bus0.UFDET_O !== 1'b0) begin
            fails++;
            $display("FAIL %s_async: d1=%b of1=%b uf1=%b d0=%b of0=%b uf0=%b, required all 0",
                     name, bus1.DATA_O, bus1.OFDET_O, bus1.UFDET_O, bus0.DATA_O, bus0.OFDET_O, bus0.UFDET_O);
        end
        rst_n = 1'b1;
        m_y1 = 0; m_x1 = 0; m_y0 = 0;
        m_of1 = 0; m_uf1 = 0; m_of0 = 0; m_uf0 = 0;
    endtask

    task automatic cmp_model(input string name);
        tests++;
        if (int'($signed(bus1.DATA_O)) !== m_y1 || bus1.OFDET_O !== m_of1 || bus1.UFDET_O !== m_uf1 ||
            int'($signed(bus0.DATA_O)) !== m_y0 || bus0.OFDET_O !== m_of0 || bus0.UFDET_O !== m_uf0) begin
            fails++;
            $display("FAIL %s: got d1=%0d of1=%b uf1=%b d0=%0d of0=%b uf0=%b, required %0d %b %b / %0d %b %b",
                     name, $signed(bus1.DATA_O), bus1.OFDET_O, bus1.UFDET_O,
                     $signed(bus0.DATA_O), bus0.OFDET_O, bus0.UFDET_O,
                     m_y1, m_of1, m_uf1, m_y0, m_of0, m_uf0);
        end
    endtask

    task automatic test_reset();
        set_in(0);
        pulse_reset("reset");
        step();
        tests++;
        if (bus1.DATA_O !== 5'd0 || bus1.OFDET_O !== 1'b0 || bus1.UFDET_O !== 1'b0) begin
            fails++;
            $display("FAIL reset_first_edge: d1=%b of1=%b uf1=%b, required 0 0 0",
                     bus1.DATA_O, bus1.OFDET_O, bus1.UFDET_O);
        end
        cmp_model("reset_model");
    endtask

    task automatic test_clamp_low();
        pulse_reset("clamp_low");
        set_in(-1);
        for (int i = 0; i < 17; i++) begin
            step();
            cmp_model("clamp_low_ramp");
        end
        tests++;
        if (bus1.DATA_O !== 5'b10000 || bus1.UFDET_O !== 1'b0) begin
            fails++;
            $display("FAIL clamp_low_reach: d1=%b uf1=%b, required 10000 0", bus1.DATA_O, bus1.UFDET_O);
        end
        step();
        tests++;
        if (bus1.DATA_O !== 5'b10000 || bus1.UFDET_O !== 1'b1 || bus1.OFDET_O !== 1'b0) begin
            fails++;
            $display("FAIL clamp_low_sat: d1=%b uf1=%b of1=%b, required 10000 1 0",
                     bus1.DATA_O, bus1.UFDET_O, bus1.OFDET_O);
        end
    endtask

    task automatic test_hold_low();
        int bad = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (bus1.DATA_O !== 5'b10000 || bus1.UFDET_O !== 1'b1 || bus1.OFDET_O !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold_low: %0d cycles off the low rail, required 0", bad);
        end
        cmp_model("hold_low_model");
    endtask

    task automatic test_reversal();
        set_in(1);
        step();
        step();
        tests++;
        if (int'($signed(bus1.DATA_O)) !== -15 || bus1.UFDET_O !== 1'b0) begin
            fails++;
            $display("FAIL reversal_leave: d1=%0d uf1=%b, required -15 0", $signed(bus1.DATA_O), bus1.UFDET_O);
        end
        for (int i = 0; i < 30; i++) begin
            step();
            cmp_model("reversal_ramp");
        end
        tests++;
        if (bus1.DATA_O !== 5'b01111 || bus1.OFDET_O !== 1'b0) begin
            fails++;
            $display("FAIL reversal_reach: d1=%b of1=%b, required 01111 0", bus1.DATA_O, bus1.OFDET_O);
        end
        step();
        tests++;
        if (bus1.DATA_O !== 5'b01111 || bus1.OFDET_O !== 1'b1) begin
            fails++;
            $display("FAIL reversal_sat: d1=%b of1=%b, required 01111 1", bus1.DATA_O, bus1.OFDET_O);
        end
    endtask

    task automatic test_reset_mid_sat();
        tests++;
        if (bus1.OFDET_O !== 1'b1) begin
            fails++;
            $display("FAIL mid_sat_pre: of1=%b, required 1", bus1.OFDET_O);
        end
        pulse_reset("mid_sat");
        step();
        step();
        tests++;
        if (int'($signed(bus1.DATA_O)) !== 1 || bus1.OFDET_O !== 1'b0) begin
            fails++;
            $display("FAIL mid_sat_resume: d1=%0d of1=%b, required 1 0", $signed(bus1.DATA_O), bus1.OFDET_O);
        end
        cmp_model("mid_sat_model");
    endtask

    task automatic test_large_step();
        pulse_reset("large");
        set_in(15);
        step();
        tests++;
        if (bus1.DATA_O !== 5'd0 || bus0.DATA_O !== 5'd15 || bus0.OFDET_O !== 1'b0) begin
            fails++;
            $display("FAIL large_edge1: d1=%0d d0=%0d of0=%b, required 0 15 0",
                     $signed(bus1.DATA_O), $signed(bus0.DATA_O), bus0.OFDET_O);
        end
        step();
        tests++;
        if (bus1.DATA_O !== 5'd15 || bus1.OFDET_O !== 1'b0 || bus0.DATA_O !== 5'd15 || bus0.OFDET_O !== 1'b1) begin
            fails++;
            $display("FAIL large_edge2: d1=%0d of1=%b d0=%0d of0=%b, required 15 0 15 1",
                     $signed(bus1.DATA_O), bus1.OFDET_O, $signed(bus0.DATA_O), bus0.OFDET_O);
        end
        step();
        tests++;
        if (bus1.DATA_O !== 5'd15 || bus1.OFDET_O !== 1'b1) begin
            fails++;
            $display("FAIL large_edge3: d1=%0d of1=%b, required 15 1", $signed(bus1.DATA_O), bus1.OFDET_O);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(int'($urandom_range(31)) - 16);
            step();
            cmp_model("random");
        end
    endtask

    task automatic test_zero();
        logic [L-1:0] held1, held0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 6; i++) begin
                set_in(int'($urandom_range(31)) - 16);
                step();
            end
            set_in(0);
            step();
            step();
            held1 = bus1.DATA_O;
            held0 = bus0.DATA_O;
            for (int i = 0; i < 4; i++) begin
                step();
                tests++;
                if (bus1.DATA_O !== held1 || bus0.DATA_O !== held0 || bus1.OFDET_O || bus1.UFDET_O ||
                    bus0.OFDET_O || bus0.UFDET_O) begin
                    fails++;
                    $display("FAIL zero_hold: d1=%b d0=%b flags=%b%b%b%b, required %b %b 0000",
                             bus1.DATA_O, bus0.DATA_O, bus1.OFDET_O, bus1.UFDET_O,
                             bus0.OFDET_O, bus0.UFDET_O, held1, held0);
                end
            end
            cmp_model("zero_model");
        end
    endtask

    initial begin
        test_reset();
        test_clamp_low();
        test_hold_low();
        test_reversal();
        test_reset_mid_sat();
        test_large_step();
        test_random();
        test_zero();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
